branch_predictor_btb: RTL
=========================

// Module: branch_predictor_btb
// PURPOSE
//  Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
//  Sits in IF beside pc_counter and produces predict_taken / predict_pc for it each cycle.
//  The prediction is a lookup on the current PC.
//  It is trained by branch resolution results from EX; mispredicts are recovered by EX flush, not here.
// PARAMETERS
//  XLEN_WIDTH   32  address/PC width
//  BTB_ENTRIES  16  number of entries; power of 2, >=2
//  IDX_BITS     $clog2(BTB_ENTRIES)  derived, not overridable
// PORTS
//  clk               in   1           rising-edge clock
//  reset             in   1           asynchronous, active-high
//  if_pc             in   XLEN_WIDTH  PC currently in IF (pc_counter output)
//  predict_taken     out  1           predicted taken for if_pc
//  predict_pc        out  XLEN_WIDTH  next-PC prediction for if_pc
//  ex_update_valid   in   1           a resolved branch/jump is reported this cycle
//  ex_update_pc      in   XLEN_WIDTH  PC of the resolved branch
//  ex_update_taken   in   1           actual direction
//  ex_update_target  in   XLEN_WIDTH  actual taken target
//  btb_flush         in   1           invalidate whole table (e.g. fence.i)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Entry = {valid, tag[XLEN_WIDTH-IDX_BITS-3:0], target[XLEN_WIDTH-1:0], ctr[1:0]}.
//  idx = pc[IDX_BITS+1:2]; tag = pc[XLEN_WIDTH-1:IDX_BITS+2]; pc[1:0] is ignored.
//  Lookup (combinational, 0-cycle):
//   - hit = valid[idx] && tag match.
//   - predict_taken = hit && ctr[1].
//   - predict_pc = predict_taken ? target : if_pc+4, mod 2^XLEN_WIDTH wrap.
//  Update at posedge when ex_update_valid=1:
//   - Hit, taken: ctr = min(ctr+1, 3); target <= ex_update_target.
//   - Hit, not-taken: ctr = max(ctr-1, 0); target unchanged.
//   - Miss, taken: allocate/overwrite the slot. valid=1, tag, target, ctr=2'b10 (weakly taken).
//   - Miss, not-taken: no table change.
//  Same-cycle lookup and update to the same idx:
//   - The lookup sees pre-update contents (no bypass).
//   - The new contents are visible the next cycle.
//  btb_flush=1 at posedge: all valid<=0, all ctr<=2'b01. This has priority over a same-cycle update, which is dropped.
//  Reset (async assert), effective immediately:
//   - All valid=0, all ctr=2'b01, so predict_taken=0 and predict_pc=if_pc+4.
//   - Tags and targets are not reset.
//  Reset asserted mid-update: the update is lost; no partial entry is written.
//  Stall is not an input: lookup is purely a function of if_pc and state; pc_counter decides use.
// CONFIGURATION
//  BP_GSHARE_EN defined:
//   - Direction counters move to a separate BTB_ENTRIES-deep PHT, indexed idx^ghr.
//   - ghr is an IDX_BITS global history register, reset 0.
//   - On each ex_update_valid, ghr <= {ghr[IDX_BITS-2:0], ex_update_taken}. Not updated on btb_flush.
//   - PHT counters update at the index formed from ex_update_pc and the pre-shift ghr; the BTB hit is still required for predict_taken.
//   - btb_flush and reset also reset all PHT counters to 2'b01; reset also clears ghr.
//  BP_GSHARE_EN undefined: per-entry counters as in BEHAVIOUR; no ghr.
// TESTING
//  T1 Reset, if_pc=0x100 -> predict_taken=0, predict_pc=0x104; likewise for any if_pc.
//  T2 Update pc=0x100, taken, target=0x200; next cycle if_pc=0x100 -> taken=1, pc=0x200; if_pc=0x140 (same idx, other tag) -> taken=0, pc=0x144.
//  T3 After T2, 2 not-taken updates at 0x100 -> ctr 2->1->0, predict_taken=0. 5 taken updates -> ctr saturates at 3; 1 not-taken -> still taken.
//  T4 Lookup if_pc=0x100 in the same cycle as the first allocating update -> taken=0; next cycle -> taken=1.
//  T5 btb_flush with a simultaneous taken update at 0x300 -> no entry hits afterwards, incl. 0x300.
//  T6 Async reset pulse between clock edges with live entries -> predict_taken drops to 0 before the next edge.
//      (BP_GSHARE_EN) history 1,0,1 then lookup -> PHT index = idx^3'b101 (BTB_ENTRIES=8).

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters, looked up combinationally on if_pc.
// Define BP_GSHARE_EN to move the counters into a gshare PHT indexed by idx ^ global history.
module branch_predictor_btb #(
    parameter int unsigned XLEN_WIDTH  = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    localparam int unsigned IDX_BITS   = $clog2(BTB_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN_WIDTH-1:0] if_pc,
    output logic                  predict_taken,
    output logic [XLEN_WIDTH-1:0] predict_pc,
    input  logic                  ex_update_valid,
    input  logic [XLEN_WIDTH-1:0] ex_update_pc,
    input  logic                  ex_update_taken,
    input  logic [XLEN_WIDTH-1:0] ex_update_target,
    input  logic                  btb_flush
);

    localparam int unsigned TAG_BITS = XLEN_WIDTH - IDX_BITS - 2;

    logic                  valid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [BTB_ENTRIES];
    logic [XLEN_WIDTH-1:0] target_q [BTB_ENTRIES];
    logic [1:0]            ctr_q    [BTB_ENTRIES];

    logic [IDX_BITS-1:0] if_idx, upd_idx, cnt_rd_idx, cnt_wr_idx;
    logic [TAG_BITS-1:0] if_tag, upd_tag;
    logic                if_hit, upd_hit;
    logic [1:0]          ctr_cur, ctr_wr_val;
    logic                ctr_wr_en;
    logic                unused_pc_bits;

    assign if_idx  = if_pc[IDX_BITS+1:2];
    assign if_tag  = if_pc[XLEN_WIDTH-1:IDX_BITS+2];
    assign upd_idx = ex_update_pc[IDX_BITS+1:2];
    assign upd_tag = ex_update_pc[XLEN_WIDTH-1:IDX_BITS+2];

    // Instructions are word aligned; the byte offset never selects an entry.
    assign unused_pc_bits = ^{if_pc[1:0], ex_update_pc[1:0]};

    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign predict_taken = if_hit && ctr_q[cnt_rd_idx][1];
    assign predict_pc    = predict_taken ? target_q[if_idx] : if_pc + XLEN_WIDTH'(4);

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q;
    logic [IDX_BITS:0]   ghr_shift;

    assign cnt_rd_idx = if_idx ^ ghr_q;
    assign cnt_wr_idx = upd_idx ^ ghr_q;
    assign ghr_shift  = {ghr_q, ex_update_taken};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (ex_update_valid && !btb_flush) begin
            ghr_q <= ghr_shift[IDX_BITS-1:0];
        end
    end
`else
    assign cnt_rd_idx = if_idx;
    assign cnt_wr_idx = upd_idx;
`endif

    assign ctr_cur = ctr_q[cnt_wr_idx];

    always_comb begin
        ctr_wr_en  = 1'b0;
        ctr_wr_val = ctr_cur;
`ifdef BP_GSHARE_EN
        // The PHT trains on every resolved branch, independent of the BTB tag.
        ctr_wr_en  = ex_update_valid;
        ctr_wr_val = ex_update_taken ? ((ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01)
                                     : ((ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01);
`else
        if (ex_update_valid && upd_hit) begin
            ctr_wr_en  = 1'b1;
            ctr_wr_val = ex_update_taken ? ((ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01)
                                         : ((ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01);
        end else if (ex_update_valid && ex_update_taken) begin
            ctr_wr_en  = 1'b1;
            ctr_wr_val = 2'b10;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || btb_flush) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            if (ex_update_valid && ex_update_taken && !upd_hit) begin
                valid_q[upd_idx] <= 1'b1;
            end
            if (ctr_wr_en) begin
                ctr_q[cnt_wr_idx] <= ctr_wr_val;
            end
        end
    end

    // Tags and targets carry no reset; a write is suppressed while reset or flush is active.
    always_ff @(posedge clk) begin
        if (!reset && !btb_flush && ex_update_valid && ex_update_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= ex_update_target;
        end
    end

endmodule
